// File: rtl/keyscan_ctrl.sv
// keyscan_ctrl: 4x4 key-matrix scanner with scan-level debounce and a
// one-deep press-event interface.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   key_col    one-hot column drive (active high)
//   key_row    row sense for the driven column (active high), key = col*4+row
//   key_state  debounced key map, bit i set while key i is held
//   key_valid  a press event is presented on key_val
//   key_val    index of the presented press event
//   key_ack    consumer accepts the event (ignored while key_valid=0)
//   key_ovf    sticky: a pending press was lost because its key was released
//   clr_ovf    synchronous clear of key_ovf (a simultaneous set wins)
module keyscan_ctrl #(
  parameter int SCAN_DIV = 4,  // cycles per column, 2..255
  parameter int DEB_CNT  = 3   // identical full scans before commit, 1..15
) (
  input  logic        clock,
  input  logic        reset,
  output logic [3:0]  key_col,
  input  logic [3:0]  key_row,
  output logic [15:0] key_state,
  output logic        key_valid,
  output logic [3:0]  key_val,
  input  logic        key_ack,
  output logic        key_ovf,
  input  logic        clr_ovf
);

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_MAX  = 4'(DEB_CNT);

  logic [7:0]  div_reg;
  logic [1:0]  col_reg;
  logic [15:0] raw_reg, cand_reg, pend_reg, state_reg;
  logic [3:0]  cnt_reg, val_reg;
  logic        valid_reg, ovf_reg;

  logic [7:0]  div_next;
  logic [1:0]  col_next;
  logic [15:0] cand_next, pend_next, state_next, snap;
  logic [3:0]  cnt_next, val_next, cnt_inc, issue_idx;
  logic        valid_next, ovf_next;
  logic        col_end, scan_end, same, commit, lost, issue;

  assign key_col   = 4'b0001 << col_reg;
  assign key_state = state_reg;
  assign key_valid = valid_reg;
  assign key_val   = val_reg;
  assign key_ovf   = ovf_reg;

  assign col_end  = (div_reg == DIV_LAST);
  assign scan_end = col_end && (col_reg == 2'd3);

  // Snapshot already includes the rows being sampled this cycle, so the
  // scan-complete comparison sees column 3 without waiting a cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_snap
      assign snap[gi*4 +: 4] = (col_end && col_reg == 2'(gi)) ? key_row
                                                              : raw_reg[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    div_next   = col_end ? 8'd0 : div_reg + 8'd1;
    col_next   = col_end ? col_reg + 2'd1 : col_reg;
    cand_next  = cand_reg;
    cnt_next   = cnt_reg;
    state_next = state_reg;
    commit     = 1'b0;
    lost       = 1'b0;
    same       = (snap == cand_reg);
    cnt_inc    = (cnt_reg >= DEB_MAX) ? DEB_MAX : cnt_reg + 4'd1;

    if (scan_end) begin
      if (same) begin
        cnt_next = cnt_inc;
        commit   = (cnt_inc == DEB_MAX);
      end else begin
        cand_next = snap;
        cnt_next  = 4'd1;
        commit    = (DEB_MAX == 4'd1);
      end
    end

    // Commit: record new presses, drop pending presses whose key let go.
    pend_next = pend_reg;
    if (commit) begin
      state_next = snap;
      pend_next  = (pend_reg | (snap & ~state_reg)) & snap;
      lost       = |(pend_reg & ~snap);
    end

    // Issue picks from the registered pending set; its clear is applied
    // on top of the commit update.
    issue     = !valid_reg && (pend_reg != 16'd0);
    issue_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pend_reg[i]) issue_idx = 4'(i);
    end

    valid_next = valid_reg;
    val_next   = val_reg;
    if (issue) begin
      pend_next[issue_idx] = 1'b0;
      valid_next           = 1'b1;
      val_next             = issue_idx;
    end else if (valid_reg && key_ack) begin
      valid_next = 1'b0;
    end

    if (lost)         ovf_next = 1'b1;
    else if (clr_ovf) ovf_next = 1'b0;
    else              ovf_next = ovf_reg;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_reg   <= 8'd0;
      col_reg   <= 2'd0;
      raw_reg   <= 16'd0;
      cand_reg  <= 16'd0;
      cnt_reg   <= 4'd0;
      state_reg <= 16'd0;
      pend_reg  <= 16'd0;
      valid_reg <= 1'b0;
      val_reg   <= 4'd0;
      ovf_reg   <= 1'b0;
    end else begin
      div_reg   <= div_next;
      col_reg   <= col_next;
      raw_reg   <= col_end ? snap : raw_reg;
      cand_reg  <= cand_next;
      cnt_reg   <= cnt_next;
      state_reg <= state_next;
      pend_reg  <= pend_next;
      valid_reg <= valid_next;
      val_reg   <= val_next;
      ovf_reg   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_keyscan_ctrl.sv
// Testbench for keyscan_ctrl: randomized key-matrix stimulus, a reference
// model built on absolute cycle time, and a scoreboard monitor.
module tb_keyscan_ctrl;
  localparam int SD  = 4;
  localparam int DEB = 3;
  localparam int SCAN = 4 * SD;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [15:0] key_state;
  logic        key_valid;
  logic [3:0]  key_val;
  logic        key_ack;
  logic        key_ovf;
  logic        clr_ovf;

  logic [15:0] keys;     // physical matrix: which keys are held
  logic        ack_en, clr_force;
  bit          running;
  int          n_vec = 0, n_bad = 0;

  always #5 clock = ~clock;

  // Matrix wiring: a held key connects its column line to its row line.
  always_comb begin
    key_row = 4'd0;
    for (int c = 0; c < 4; c++)
      if (key_col[c]) key_row = key_row | keys[c*4 +: 4];
  end

  keyscan_ctrl #(.SCAN_DIV(SD), .DEB_CNT(DEB)) dut (
    .clock(clock), .reset(reset), .key_col(key_col), .key_row(key_row),
    .key_state(key_state), .key_valid(key_valid), .key_val(key_val),
    .key_ack(key_ack), .key_ovf(key_ovf), .clr_ovf(clr_ovf)
  );

  typedef struct packed {
    logic [3:0]  col;
    logic [15:0] ks;
    logic        valid;
    logic [3:0]  val;
    logic        ovf;
  } exp_t;

  exp_t       cyc_q[$];
  logic [3:0] ev_q[$];

  // Reference model state (cycle t counted from reset release)
  int          t;
  logic [15:0] m_raw, m_cand, m_ks, m_pend;
  int          m_cnt;
  logic        m_valid, m_ovf;
  logic [3:0]  m_val;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    t = 0; m_raw = '0; m_cand = '0; m_ks = '0; m_pend = '0;
    m_cnt = 0; m_valid = 0; m_ovf = 0; m_val = '0;
  endtask

  // Predict the effect of the coming rising edge with the current inputs.
  task automatic model_step();
    int col;
    logic [15:0] np;
    bit commit, lost;
    exp_t e;
    col = (t / SD) % 4;
    commit = 0; lost = 0;
    if (t % SD == SD - 1)
      for (int r = 0; r < 4; r++) m_raw[col*4 + r] = keys[col*4 + r];
    if (t % SCAN == SCAN - 1) begin
      if (m_raw != m_cand) begin
        m_cand = m_raw; m_cnt = 1;
      end else if (m_cnt < DEB) m_cnt++;
      commit = (m_cnt == DEB);
    end
    np = m_pend;
    if (commit) begin
      lost = ((m_pend & ~m_cand) != 0);
      np   = (m_pend | (m_cand & ~m_ks)) & m_cand;
      m_ks = m_cand;
    end
    if (!m_valid && m_pend != 0) begin
      int idx = 0;
      while (!m_pend[idx]) idx++;
      np[idx] = 1'b0;
      m_valid = 1'b1;
      m_val   = 4'(idx);
      ev_q.push_back(4'(idx));
    end else if (m_valid && key_ack) begin
      m_valid = 1'b0;
    end
    m_pend = np;
    if (lost) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    t++;
    e.col = 4'(1 << ((t / SD) % 4));
    e.ks = m_ks; e.valid = m_valid; e.val = m_val; e.ovf = m_ovf;
    cyc_q.push_back(e);
  endtask

  // One cycle: choose inputs at the falling edge, predict, advance.
  task automatic tick();
    key_ack = ack_en ? 1'($urandom_range(0, 1)) : 1'b0;
    clr_ovf = clr_force | ($urandom_range(0, 63) == 0);
    model_step();
    @(negedge clock);
  endtask

  task automatic run_cycles(int n);
    repeat (n) tick();
  endtask

  // Monitor: compare what the DUT shows after each edge with the scoreboard.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (running) begin
        if (cyc_q.size() == 0) begin
          check("cycle_queue_empty", 1, 0);
        end else begin
          e = cyc_q.pop_front();
          check("key_col", 32'(key_col), 32'(e.col));
          check("key_state", 32'(key_state), 32'(e.ks));
          check("key_valid", 32'(key_valid), 32'(e.valid));
          check("key_ovf", 32'(key_ovf), 32'(e.ovf));
          if (e.valid) check("key_val", 32'(key_val), 32'(e.val));
        end
        if (key_valid && !prev_valid) begin
          if (ev_q.size() == 0) check("unexpected_event", 32'(key_val), 32'hFF);
          else check("event_order", 32'(key_val), 32'(ev_q.pop_front()));
        end
      end
      prev_valid = key_valid;
    end
  end

  task automatic check_reset_values(string tag);
    check({tag, "_col"}, 32'(key_col), 32'h1);
    check({tag, "_state"}, 32'(key_state), 32'h0);
    check({tag, "_valid"}, 32'(key_valid), 32'h0);
    check({tag, "_val"}, 32'(key_val), 32'h0);
    check({tag, "_ovf"}, 32'(key_ovf), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; keys = '0; key_ack = 0; clr_ovf = 0;
    ack_en = 1; clr_force = 0; running = 0;
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_values("init");
    reset = 1'b1;
    running = 1;

    // Idle scanning, no keys
    run_cycles(2 * SCAN);

    // Key 6 held steadily, then released
    keys = 16'h0040; run_cycles(5 * SCAN);
    keys = 16'h0000; run_cycles(4 * SCAN);

    // Key 6 bouncing every scan
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      run_cycles(SCAN);
    end
    keys = 16'h0000; run_cycles(4 * SCAN);

    // Keys 3 and 9 together, events held until acked
    ack_en = 0; keys = 16'h0208; run_cycles(5 * SCAN);
    ack_en = 1; run_cycles(3 * SCAN);
    keys = 16'h0000; run_cycles(4 * SCAN);

    // Keys 3 and 9, 9 released before 3 is acked -> overflow, then clear
    ack_en = 0; keys = 16'h0208; run_cycles(4 * SCAN);
    keys = 16'h0008; run_cycles(4 * SCAN);
    ack_en = 1; run_cycles(2 * SCAN);
    clr_force = 1; tick(); clr_force = 0;
    keys = 16'h0000; run_cycles(4 * SCAN);

    // Random sparse key patterns with random hold times and ack behaviour
    for (int i = 0; i < 25; i++) begin
      keys   = 16'($urandom & $urandom & $urandom);
      ack_en = ($urandom_range(0, 3) != 0);
      run_cycles($urandom_range(SCAN, 5 * SCAN));
    end
    ack_en = 1; keys = 16'h0000; run_cycles(6 * SCAN);

    // Asynchronous reset while an event is presented
    ack_en = 0; keys = 16'h0020;
    for (int i = 0; i < 10 * SCAN && !m_valid; i++) tick();
    check("pre_reset_valid", 32'(key_valid), 32'h1);
    running = 0;
    #3;
    reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    cyc_q.delete(); ev_q.delete();
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    running = 1;
    ack_en = 1; run_cycles(5 * SCAN);
    keys = 16'h0000; run_cycles(4 * SCAN);

    running = 0;
    @(posedge clock); #2;
    check("events_left_over", 32'(ev_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/keyscan_ctrl.md
KEYSCAN_CTRL -- requirements
Module: keyscan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4: clock cycles each column is driven before its rows are sampled (legal range 2..255).
REQ-002 The block SHALL have parameter DEB_CNT, default 3: number of consecutive identical full scans needed to commit the key state (legal range 1..15).
REQ-003 Port clock  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port key_col  output  4: one-hot, active-high column drive for the 4x4 key matrix.
REQ-006 Port key_row  input  4: active-high row sense; key index = col*4 + row.
REQ-007 Port key_state  output  16: debounced key state, bit i = 1 while key i is held.
REQ-008 Port key_valid  output  1: a key-press event is held in key_val.
REQ-009 Port key_val  output  4: index (0-15) of the held key-press event.
REQ-010 Port key_ack  input  1: consumer accepts the event when key_valid=1.
REQ-011 Port key_ovf  output  1: sticky flag, a press event was lost.
REQ-012 Port clr_ovf  input  1: synchronous clear of key_ovf.

Function
REQ-013 Scanning SHALL use a divider counter (0..SCAN_DIV-1) and a column counter (0..3), with key_col = 1 << column.
REQ-014 The column counter SHALL advance, wrapping 3->0, in the cycle the divider equals SCAN_DIV-1; the divider SHALL then wrap to 0.
REQ-015 In that same cycle, key_row SHALL be sampled into raw[col*4+3 : col*4]; one full scan takes 4*SCAN_DIV cycles.
REQ-016 At the end of column 3 (scan complete), the raw snapshot SHALL be compared with a candidate register.
REQ-017 If the snapshot differs from the candidate, the candidate SHALL be loaded with the snapshot and stable_cnt SHALL be set to 1.
REQ-018 If the snapshot equals the candidate, stable_cnt SHALL increment, saturating at DEB_CNT.
REQ-019 In the scan-complete cycle where stable_cnt reaches (or is at) DEB_CNT, the block SHALL commit: key_state <= candidate, visible the next cycle.
REQ-020 At commit, pending SHALL become (pending | (candidate & ~key_state)) & candidate, where pending is a 16-bit register of unreported presses.
REQ-021 If a commit clears a pending bit through a key release, key_ovf SHALL set.
REQ-022 Event issue: when key_valid=0 and pending != 0, the block SHALL load key_val with the lowest set index, clear that pending bit, and set key_valid=1, all on the next edge.
REQ-023 If key_valid=1 and key_ack=1, key_valid SHALL clear on the next edge; key_val SHALL keep its last value.
REQ-024 A new event SHALL NOT load in the cycle key_valid clears, so there is a minimum of one idle cycle between events.
REQ-025 key_ack SHALL be ignored while key_valid=0.
REQ-026 key_valid and key_val SHALL stay stable until acknowledged.
REQ-027 If commit and issue touch the same pending bit in one cycle, the issue clear SHALL be applied after the commit update.
REQ-028 key_ovf SHALL clear when clr_ovf=1; if a set condition occurs in the same cycle, set SHALL win.
REQ-029 A key held continuously SHALL generate exactly one event; a re-press generates a new event only after a committed release.

Reset
REQ-030 While reset=0, immediately and asynchronously: key_col=4'b0001, both counters=0, raw, candidate, pending and key_state=0, stable_cnt=0, key_valid=0, key_val=0, key_ovf=0.
REQ-031 Reset asserted mid-event or mid-scan SHALL discard all state with no partial event; scanning SHALL restart at column 0 on the first edge after release.

Verification (SCAN_DIV=4, DEB_CNT=3)
REQ-032 Release reset, key_row=0 -> key_col=0001 for 4 cycles, then 0010, 0100, 1000, and back to 0001 at cycle 16; key_valid stays 0.
REQ-033 Hold key 6 (row 2 whenever key_col=0010) steady -> key_state=16'h0040 after 3 full scans, key_valid=1, key_val=6; key_ack=1 for one cycle -> key_valid=0; no further event while the key is held.
REQ-034 Key 6 toggled every scan for 6 scans -> key_state stays 0 and no event is issued.
REQ-035 Keys 3 and 9 pressed together, no ack -> key_val=3 is held; ack -> after 1 idle cycle key_valid=1, key_val=9.
REQ-036 Keys 3 and 9 pressed, 9 released before 3 is acked -> key_ovf=1 after the release commits; after ack no event for 9; clr_ovf=1 -> key_ovf=0.
REQ-037 reset pulsed low while key_valid=1 -> all outputs take their REQ-030 values within the same cycle; with the key still held after release, an event reissues after 3 scans.
